// File: rtl/tf_step_scheduler.sv
// Sequences one time step over a cascade of sta/done_sig stages: latch strobe, then each stage in order.
// Optional STEP_PERF_EN adds last_step_cycles (cycles from step_req to step_done, saturating).
module tf_step_scheduler #(
  parameter int NUM_STAGE = 4,
  parameter int STG_W     = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rst_user,
  input  logic                 step_req,
  input  logic [NUM_STAGE-1:0] done_sig,
  output logic [NUM_STAGE-1:0] sta,
  output logic                 control_valuation_sig,
  output logic                 first_step,
  output logic                 busy,
  output logic                 step_done,
  output logic                 overrun,
  output logic                 timeout_err,
  output logic [STG_W-1:0]     err_stage,
`ifdef STEP_PERF_EN
  output logic [15:0]          last_step_cycles,
`endif
  output logic [31:0]          step_count
);

  typedef enum logic [2:0] {IDLE, LATCH, ISSUE, WAIT, DONE, ERR} state_t;

  state_t                 state, state_n;
  logic [STG_W-1:0]       idx;
  logic [15:0]            timer;
  logic [NUM_STAGE-1:0]   sel;
  logic                   done_cur, last_stg;

  // One-hot select avoids indexing done_sig/sta with a wider index.
  assign sel      = NUM_STAGE'(1) << idx;
  assign done_cur = |(done_sig & sel);
  assign last_stg = (idx == STG_W'(NUM_STAGE - 1));

  always_comb begin
    state_n               = state;
    sta                   = '0;
    control_valuation_sig = 1'b0;
    step_done             = 1'b0;
    busy                  = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (step_req) state_n = LATCH;
      end
      LATCH: begin
        control_valuation_sig = 1'b1;
        state_n               = ISSUE;
      end
      ISSUE: begin
        sta     = sel;
        state_n = WAIT;
      end
      WAIT: begin
        // done takes priority over a coincident timeout
        if (done_cur)                    state_n = last_stg ? DONE : ISSUE;
        else if (timer == 16'(TIMEOUT)) state_n = ERR;
      end
      DONE: begin
        step_done = 1'b1;
        state_n   = IDLE;
      end
      ERR:     busy = 1'b0;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      first_step  <= 1'b1;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      err_stage   <= '0;
      step_count  <= '0;
    end else if (rst_user) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      first_step  <= 1'b1;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      err_stage   <= '0;
      step_count  <= '0;
    end else begin
      state <= state_n;
      if (step_req && state != IDLE) overrun <= 1'b1;
      case (state)
        LATCH: idx   <= '0;
        ISSUE: timer <= '0;
        WAIT: begin
          timer <= timer + 16'd1;
          if (done_cur && !last_stg) idx <= idx + STG_W'(1);
          if (state_n == ERR) begin
            timeout_err <= 1'b1;
            err_stage   <= idx;
          end
        end
        DONE: begin
          step_count <= step_count + 32'd1;
          first_step <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef STEP_PERF_EN
  logic [15:0] perf_cnt;
  logic [15:0] perf_inc;

  assign perf_inc = (perf_cnt == 16'hFFFF) ? perf_cnt : perf_cnt + 16'd1;

  // perf_cnt is 0 in the cycle after acceptance, so the DONE capture adds one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt         <= '0;
      last_step_cycles <= '0;
    end else if (rst_user) begin
      perf_cnt         <= '0;
      last_step_cycles <= '0;
    end else begin
      perf_cnt <= (state == IDLE && step_req) ? 16'd0 : perf_inc;
      if (state == DONE) last_step_cycles <= perf_inc;
    end
  end
`endif

endmodule
